// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC owner with a req/ack fetch handshake that holds one instruction for Control.
module instruction_fetch_unit #(
  parameter int DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC = 32'h0040_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  imem_req_o,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_ack_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  input  logic                  stall_i,
  input  logic                  redirect_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  output logic                  inst_valid_o,
  output logic [DATA_WIDTH-1:0] inst_o,
  output logic [6:0]            opcode_o,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] pc_plus4_o,
  output logic                  misalign_o
);
  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);
  typedef enum logic [1:0] {FETCH, HOLD, FLUSH} state_t;
  state_t state, state_d;
  logic [DATA_WIDTH-1:0] pc, pc_d, flush_addr, flush_addr_d, inst, inst_d;
  logic valid, valid_d, misalign, misalign_d, started, req, ack;
  // started keeps req low for the first cycle after reset release
  assign req = started && state != HOLD;
  assign ack = req && imem_ack_i;
  always_comb begin
    state_d = state;
    pc_d = pc;
    flush_addr_d = flush_addr;
    inst_d = inst;
    valid_d = valid;
    misalign_d = misalign;
    if (redirect_i) begin
      pc_d = {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};
      misalign_d = misalign || redirect_pc_i[1:0] != 2'b00;
      valid_d = 1'b0;
      inst_d = NOP;
      state_d = (req && !ack) ? FLUSH : FETCH;
      flush_addr_d = state == FLUSH ? flush_addr : pc;
    end else if (state == FETCH && ack) begin
      inst_d = imem_rdata_i;
      valid_d = 1'b1;
      state_d = HOLD;
    end else if (state == HOLD && !stall_i) begin
      pc_d = pc + DATA_WIDTH'(4);
      valid_d = 1'b0;
      inst_d = NOP;
      state_d = FETCH;
    end else if (state == FLUSH && ack) begin
      state_d = FETCH;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
      pc <= RESET_PC;
      flush_addr <= RESET_PC;
      inst <= NOP;
      valid <= 1'b0;
      misalign <= 1'b0;
      started <= 1'b0;
    end else begin
      state <= state_d;
      pc <= pc_d;
      flush_addr <= flush_addr_d;
      inst <= inst_d;
      valid <= valid_d;
      misalign <= misalign_d;
      started <= 1'b1;
    end
  end
  assign imem_req_o = req;
  assign imem_addr_o = state == FLUSH ? flush_addr : pc;
  assign inst_valid_o = valid;
  assign inst_o = inst;
  assign opcode_o = valid ? inst[6:0] : 7'b0000000;
  assign pc_o = pc;
  assign pc_plus4_o = pc + DATA_WIDTH'(4);
  assign misalign_o = misalign;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed fetch scenarios with a scoreboard monitor on presented instructions.
module tb_instruction_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 1'b0, reset = 1'b0;
  logic imem_req_o, imem_ack_i = 1'b0, stall_i = 1'b0, redirect_i = 1'b0;
  logic [31:0] imem_addr_o, imem_rdata_i = '0, redirect_pc_i = '0;
  logic inst_valid_o, misalign_o;
  logic [31:0] inst_o, pc_o, pc_plus4_o;
  logic [6:0] opcode_o;
  int tests = 0, fails = 0;
  logic [63:0] exp_q[$];
  logic prev_valid = 1'b0;

  instruction_fetch_unit dut (
    .clk(clk), .reset(reset), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i), .stall_i(stall_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i), .inst_valid_o(inst_valid_o),
    .inst_o(inst_o), .opcode_o(opcode_o), .pc_o(pc_o), .pc_plus4_o(pc_plus4_o),
    .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (inst_valid_o && !prev_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_inst", inst_o, 32'hxxxx_xxxx);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("inst", inst_o, e[31:0]);
        check("opcode", {25'd0, opcode_o}, {25'd0, e[6:0]});
        check("pc", pc_o, e[63:32]);
        check("pc_plus4", pc_plus4_o, e[63:32] + 32'd4);
      end
    end
    prev_valid = inst_valid_o;
  end

  task automatic wait_req(input logic [31:0] addr);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!imem_req_o && n < 20);
    check("req_seen", {31'd0, imem_req_o}, 32'd1);
    check("req_addr", imem_addr_o, addr);
  endtask

  task automatic do_ack(input logic [31:0] data, input logic [31:0] pc, input bit push);
    imem_ack_i = 1'b1;
    imem_rdata_i = data;
    if (push) exp_q.push_back({pc, data});
    @(negedge clk);
    imem_ack_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    check("rst_req", {31'd0, imem_req_o}, 32'd0);
    check("rst_valid", {31'd0, inst_valid_o}, 32'd0);
    check("rst_inst", inst_o, NOP);
    check("rst_opcode", {25'd0, opcode_o}, 32'd0);
    check("rst_pc", pc_o, RST_PC);
    check("rst_misalign", {31'd0, misalign_o}, 32'd0);
    reset = 1'b1;
    // sequential fetch
    wait_req(32'h0040_0000); do_ack(32'h0050_0093, 32'h0040_0000, 1);
    wait_req(32'h0040_0004); do_ack(32'h0000_a103, 32'h0040_0004, 1);
    wait_req(32'h0040_0008); do_ack(32'h0020_8233, 32'h0040_0008, 1);
    // stall in HOLD
    wait_req(32'h0040_000c);
    stall_i = 1'b1;
    do_ack(32'h1234_50b7, 32'h0040_000c, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_inst", inst_o, 32'h1234_50b7);
      check("stall_pc", pc_o, 32'h0040_000c);
      check("stall_valid", {31'd0, inst_valid_o}, 32'd1);
      check("stall_noreq", {31'd0, imem_req_o}, 32'd0);
    end
    stall_i = 1'b0;
    // redirect from HOLD
    wait_req(32'h0040_0010);
    stall_i = 1'b1;
    do_ack(32'h0040_006f, 32'h0040_0010, 1);
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0040_0100;
    @(negedge clk);
    redirect_i = 1'b0;
    stall_i = 1'b0;
    check("rd_valid", {31'd0, inst_valid_o}, 32'd0);
    check("rd_opcode", {25'd0, opcode_o}, 32'd0);
    check("rd_inst", inst_o, NOP);
    wait_req(32'h0040_0100); do_ack(32'hfe01_0113, 32'h0040_0100, 1);
    // redirect while request pending, ack three cycles later
    wait_req(32'h0040_0104);
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0040_0200;
    @(negedge clk);
    redirect_i = 1'b0;
    check("flush_req", {31'd0, imem_req_o}, 32'd1);
    check("flush_addr", imem_addr_o, 32'h0040_0104);
    @(negedge clk);
    check("flush_addr2", imem_addr_o, 32'h0040_0104);
    check("flush_valid", {31'd0, inst_valid_o}, 32'd0);
    @(negedge clk);
    do_ack(32'hdead_beef, 32'h0, 0);
    check("flush_drop_valid", {31'd0, inst_valid_o}, 32'd0);
    wait_req(32'h0040_0200); do_ack(32'h00c0_0513, 32'h0040_0200, 1);
    // misaligned redirect coinciding with an ack
    wait_req(32'h0040_0204);
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0040_0102;
    do_ack(32'hbad0_0013, 32'h0, 0);
    redirect_i = 1'b0;
    check("mis_valid", {31'd0, inst_valid_o}, 32'd0);
    check("mis_flag", {31'd0, misalign_o}, 32'd1);
    check("mis_pc", pc_o, 32'h0040_0100);
    wait_req(32'h0040_0100); do_ack(32'h0010_0073, 32'h0040_0100, 1);
    // wrap from the top of the address space
    wait_req(32'h0040_0104);
    stall_i = 1'b1;
    do_ack(32'h0000_0033, 32'h0040_0104, 1);
    check("mis_sticky", {31'd0, misalign_o}, 32'd1);
    redirect_i = 1'b1;
    redirect_pc_i = 32'hffff_fffc;
    @(negedge clk);
    redirect_i = 1'b0;
    stall_i = 1'b0;
    wait_req(32'hffff_fffc);
    check("wrap_plus4", pc_plus4_o, 32'h0);
    do_ack(32'h0000_0493, 32'hffff_fffc, 1);
    wait_req(32'h0000_0000);
    stall_i = 1'b1;
    do_ack(32'h0ff0_0593, 32'h0000_0000, 1);
    // asynchronous reset in HOLD
    #2 reset = 1'b0;
    #1;
    check("arst_valid", {31'd0, inst_valid_o}, 32'd0);
    check("arst_inst", inst_o, NOP);
    check("arst_req", {31'd0, imem_req_o}, 32'd0);
    check("arst_pc", pc_o, RST_PC);
    check("arst_misalign", {31'd0, misalign_o}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    stall_i = 1'b0;
    wait_req(RST_PC); do_ack(32'h0000_0297, RST_PC, 1);
    repeat (4) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
